// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_ACK,
        S_DONE
    } lsu_state_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_ILLEGAL  = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } lsu_err_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane generation, access legality checks and load-data extraction for the LSU.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wr_data,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_offset,
    input  logic [31:0] i_rd_word,
    output logic [3:0]  o_sel,
    output logic [31:0] o_wr_data,
    output logic        o_misaligned,
    output logic        o_illegal,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_shifted;

    // funct3[1:0] encodes the access size for both loads and stores
    always_comb begin
        o_illegal    = i_is_store ? i_funct3[2]
                                  : ((i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11));
        o_misaligned = ((i_funct3[1:0] == 2'b01) && i_offset[0]) ||
                       (i_funct3[1] && (i_offset != 2'b00));
        o_sel        = 4'b1111;
        o_wr_data    = '0;
        if (i_is_store) begin
            case (i_funct3[1:0])
                2'b00: begin
                    o_sel     = 4'b0001 << i_offset;
                    o_wr_data = {4{i_wr_data[7:0]}};
                end
                2'b01: begin
                    o_sel     = 4'b0011 << {i_offset[1], 1'b0};
                    o_wr_data = {2{i_wr_data[15:0]}};
                end
                default: o_wr_data = i_wr_data;
            endcase
        end
    end

    assign w_shifted = i_rd_word >> {i_ld_offset, 3'b000};

    always_comb begin
        case (i_ld_funct3)
            F3_B:    o_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    o_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_BU:   o_ld_data = {24'h0, w_shifted[7:0]};
            F3_HU:   o_ld_data = {16'h0, w_shifted[15:0]};
            default: o_ld_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one pipelined-Wishbone access per request, pipeline held via mem_stall.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wr_data,
    output logic        mem_stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rd_data,
    output logic [1:0]  rsp_err_code,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_wr_en,
    output logic [31:0] wb_addr,
    output logic [31:0] wb_wr_data,
    output logic [3:0]  wb_sel,
    input  logic        wb_ack,
    input  logic        wb_stall,
    input  logic [31:0] wb_rd_data
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t       r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next, w_cnt_inc;
    logic [2:0]       r_funct3, w_funct3_next;
    logic [1:0]       r_offset, w_offset_next;
    logic             r_cyc, w_cyc_next;
    logic             r_stb, w_stb_next;
    logic             r_wr_en, w_wr_en_next;
    logic [31:0]      r_addr, w_addr_next;
    logic [31:0]      r_wdata, w_wdata_next;
    logic [3:0]       r_sel, w_sel_next;
    logic             r_rsp_valid, w_rsp_valid_next;
    logic [31:0]      r_rsp_data, w_rsp_data_next;
    lsu_err_t         r_err, w_err_next;

    logic [3:0]       w_sel;
    logic [31:0]      w_wdata;
    logic [31:0]      w_ld_data;
    logic             w_misaligned;
    logic             w_illegal;
    logic             w_timeout;

    lsu_align u_align (
        .i_is_store   (req_is_store),
        .i_funct3     (req_funct3),
        .i_offset     (req_addr[1:0]),
        .i_wr_data    (req_wr_data),
        .i_ld_funct3  (r_funct3),
        .i_ld_offset  (r_offset),
        .i_rd_word    (wb_rd_data),
        .o_sel        (w_sel),
        .o_wr_data    (w_wdata),
        .o_misaligned (w_misaligned),
        .o_illegal    (w_illegal),
        .o_ld_data    (w_ld_data)
    );

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_funct3_next    = r_funct3;
        w_offset_next    = r_offset;
        w_cyc_next       = r_cyc;
        w_stb_next       = r_stb;
        w_wr_en_next     = r_wr_en;
        w_addr_next      = r_addr;
        w_wdata_next     = r_wdata;
        w_sel_next       = r_sel;
        w_rsp_valid_next = 1'b0;
        w_rsp_data_next  = r_rsp_data;
        w_err_next       = r_err;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (req_valid) begin
                    if (w_illegal || w_misaligned) begin
                        w_rsp_valid_next = 1'b1;
                        w_rsp_data_next  = '0;
                        w_err_next       = w_illegal ? ERR_ILLEGAL : ERR_MISALIGN;
                        w_state_next     = S_DONE;
                    end else begin
                        w_funct3_next = req_funct3;
                        w_offset_next = req_addr[1:0];
                        w_cyc_next    = 1'b1;
                        w_stb_next    = 1'b1;
                        w_wr_en_next  = req_is_store;
                        w_addr_next   = {req_addr[31:2], 2'b00};
                        w_wdata_next  = w_wdata;
                        w_sel_next    = w_sel;
                        w_state_next  = S_REQ;
                    end
                end
            end
            S_REQ, S_WAIT_ACK: begin
                w_cnt_next = w_cnt_inc;
                // An ack on the final cycle still wins over the timeout
                if (wb_ack && !((r_state == S_REQ) && wb_stall)) begin
                    w_cyc_next       = 1'b0;
                    w_stb_next       = 1'b0;
                    w_rsp_valid_next = 1'b1;
                    w_rsp_data_next  = r_wr_en ? '0 : w_ld_data;
                    w_err_next       = ERR_OK;
                    w_state_next     = S_DONE;
                end else if (w_timeout) begin
                    w_cyc_next       = 1'b0;
                    w_stb_next       = 1'b0;
                    w_rsp_valid_next = 1'b1;
                    w_rsp_data_next  = '0;
                    w_err_next       = ERR_TIMEOUT;
                    w_state_next     = S_DONE;
                end else if ((r_state == S_REQ) && !wb_stall) begin
                    w_stb_next   = 1'b0;
                    w_state_next = S_WAIT_ACK;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_funct3    <= '0;
            r_offset    <= '0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_wr_en     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_sel       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_err       <= ERR_OK;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_funct3    <= w_funct3_next;
            r_offset    <= w_offset_next;
            r_cyc       <= w_cyc_next;
            r_stb       <= w_stb_next;
            r_wr_en     <= w_wr_en_next;
            r_addr      <= w_addr_next;
            r_wdata     <= w_wdata_next;
            r_sel       <= w_sel_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_data  <= w_rsp_data_next;
            r_err       <= w_err_next;
        end
    end

    assign mem_stall    = req_valid & ~r_rsp_valid;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rd_data  = r_rsp_data;
    assign rsp_err_code = r_err;
    assign wb_cyc       = r_cyc;
    assign wb_stb       = r_stb;
    assign wb_wr_en     = r_wr_en;
    assign wb_addr      = r_addr;
    assign wb_wr_data   = r_wdata;
    assign wb_sel       = r_sel;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-level reference model and a word-level memory slave.
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wr_data = '0;
    logic        mem_stall, rsp_valid;
    logic [31:0] rsp_rd_data;
    logic [1:0]  rsp_err_code;
    logic        wb_cyc, wb_stb, wb_wr_en;
    logic [31:0] wb_addr, wb_wr_data;
    logic [3:0]  wb_sel;
    logic        wb_ack = 1'b0;
    logic        wb_stall = 1'b0;
    logic [31:0] wb_rd_data = '0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_is_store(req_is_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wr_data(req_wr_data),
        .mem_stall(mem_stall), .rsp_valid(rsp_valid), .rsp_rd_data(rsp_rd_data),
        .rsp_err_code(rsp_err_code),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_wr_en(wb_wr_en), .wb_addr(wb_addr),
        .wb_wr_data(wb_wr_data), .wb_sel(wb_sel),
        .wb_ack(wb_ack), .wb_stall(wb_stall), .wb_rd_data(wb_rd_data)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model (byte-addressed memory) ----------------
    logic [7:0] mdl_mem [0:255];

    function automatic int unsigned mdl_nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [1:0] mdl_err(input bit st, input logic [2:0] f3, input logic [31:0] a);
        if (st ? (f3 >= 3'd4) : (f3 == 3'd3 || f3 >= 3'd6)) return 2'b10;
        if ((a % mdl_nbytes(f3)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        int unsigned nb;
        nb = mdl_nbytes(f3);
        v = '0;
        for (int unsigned i = 0; i < nb; i++) v |= 32'(mdl_mem[8'(a + i)]) << (8 * i);
        if (f3 < 3'd4 && nb < 4 && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8 * nb);
        return v;
    endfunction

    function automatic logic [3:0] mdl_sel(input bit st, input logic [2:0] f3, input logic [31:0] a);
        if (!st) return 4'hF;
        return 4'(((1 << mdl_nbytes(f3)) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] mdl_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] v;
        int unsigned nb;
        nb = mdl_nbytes(f3);
        v = '0;
        for (int unsigned k = 0; k < 4; k++) v[8*k +: 8] = 8'(d >> (8 * (k % nb)));
        return v;
    endfunction

    // ---------------- memory slave (word array, pipelined Wishbone) ----------------
    logic [31:0] slv_mem [0:63];
    logic [31:0] slv_rdata = '0;
    bit          slv_pend = 1'b0;
    bit          slv_noack = 1'b0;
    int          slv_stall_left = 0;

    always @(negedge clk) begin
        wb_ack     = slv_pend;
        wb_rd_data = slv_pend ? slv_rdata : 32'h0;
        slv_pend   = 1'b0;
        wb_stall   = 1'b0;
        if (rst_n && wb_cyc && wb_stb) begin
            if (slv_stall_left > 0) begin
                wb_stall = 1'b1;
                slv_stall_left--;
            end else begin
                if (wb_wr_en)
                    for (int k = 0; k < 4; k++)
                        if (wb_sel[k]) slv_mem[wb_addr[7:2]][8*k +: 8] = wb_wr_data[8*k +: 8];
                slv_rdata = slv_mem[wb_addr[7:2]];
                slv_pend  = !slv_noack;
            end
        end
    end

    // ---------------- per-cycle compare against model ----------------
    typedef struct {
        logic [31:0] rd;
        logic [1:0]  err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_addr = '0, exp_wdata = '0;
    logic [3:0]  exp_sel = '0;
    logic        exp_we = 1'b0;
    int          cyc_cnt = 0, stb_cnt = 0;
    logic [31:0] seen_addr = '0, seen_wdata = '0;
    logic [3:0]  seen_sel = '0;

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            chk("mem_stall", 32'(mem_stall), 32'(req_valid & ~rsp_valid));
            if (wb_cyc) cyc_cnt++;
            if (wb_cyc && wb_stb) begin
                stb_cnt++;
                chk("wb_addr", wb_addr, exp_addr);
                chk("wb_sel", 32'(wb_sel), 32'(exp_sel));
                chk("wb_wr_en", 32'(wb_wr_en), 32'(exp_we));
                if (exp_we) chk("wb_wr_data", wb_wr_data, exp_wdata);
                seen_addr  = wb_addr;
                seen_sel   = wb_sel;
                seen_wdata = wb_wr_data;
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response");
                end else begin
                    e = exp_q.pop_front();
                    chk("model rsp_rd_data", rsp_rd_data, e.rd);
                    chk("model rsp_err_code", 32'(rsp_err_code), 32'(e.err));
                end
            end
        end
    end

    // ---------------- directed request with literal pins ----------------
    task automatic run_req(input string name, input bit st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d, input bit to,
                           input logic [31:0] lit_rd, input logic [1:0] lit_err,
                           input int lit_lat, input int lit_cyc, input int lit_stb,
                           input logic [31:0] lit_addr, input logic [3:0] lit_sel,
                           input logic [31:0] lit_wdata);
        exp_t e;
        int   lat;
        e.err = to ? 2'b11 : mdl_err(st, f3, a);
        e.rd  = (st || e.err != 2'b00) ? 32'h0 : mdl_load(f3, a);
        if (st && e.err == 2'b00)
            for (int unsigned i = 0; i < mdl_nbytes(f3); i++) mdl_mem[8'(a + i)] = 8'(d >> (8 * i));
        exp_addr  = {a[31:2], 2'b00};
        exp_sel   = mdl_sel(st, f3, a);
        exp_we    = st;
        exp_wdata = mdl_wdata(f3, d);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc_cnt      = 0;
        stb_cnt      = 0;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = a;
        req_wr_data  = d;
        req_valid    = 1'b1;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        req_valid = 1'b0;
        if (!rsp_valid) begin
            total++;
            bad++;
            $display("FAIL %s no_response: got none within 40 cycles expected rsp_valid", name);
        end else begin
            chk({name, " rd"}, rsp_rd_data, lit_rd);
            chk({name, " err"}, 32'(rsp_err_code), 32'(lit_err));
            chk({name, " latency"}, 32'(lat), 32'(lit_lat));
            chk({name, " cyc_cycles"}, 32'(cyc_cnt), 32'(lit_cyc));
            chk({name, " stb_cycles"}, 32'(stb_cnt), 32'(lit_stb));
            chk({name, " cyc_after"}, 32'(wb_cyc), 32'(0));
            if (lit_stb > 0) begin
                chk({name, " addr"}, seen_addr, lit_addr);
                chk({name, " sel"}, 32'(seen_sel), 32'(lit_sel));
                if (st) chk({name, " wdata"}, seen_wdata, lit_wdata);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;
        for (int i = 0; i < 64; i++) slv_mem[i] = 32'h0;

        // reset values, mem_stall follows req_valid while held in reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst wb_cyc", 32'(wb_cyc), 32'(0));
        chk("rst wb_stb", 32'(wb_stb), 32'(0));
        chk("rst rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst rsp_rd_data", rsp_rd_data, 32'h0);
        chk("rst err", 32'(rsp_err_code), 32'(0));
        chk("rst wb_addr", wb_addr, 32'h0);
        chk("rst wb_sel", 32'(wb_sel), 32'(0));
        chk("rst wb_wr_data", wb_wr_data, 32'h0);
        chk("rst wb_wr_en", 32'(wb_wr_en), 32'(0));
        req_valid = 1'b1;
        #1;
        chk("rst mem_stall", 32'(mem_stall), 32'(1));
        req_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        //      name     st f3      addr      data          to rd            err lat cyc stb addr      sel    wdata
        run_req("sw10",  1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0,        2'd0, 3, 2, 1, 32'h10, 4'hF, 32'hDEADBEEF);
        run_req("lw10",  0, 3'b010, 32'h10, 32'h0,        0, 32'hDEADBEEF, 2'd0, 3, 2, 1, 32'h10, 4'hF, 32'h0);
        run_req("sb13",  1, 3'b000, 32'h13, 32'h000000A5, 0, 32'h0,        2'd0, 3, 2, 1, 32'h10, 4'h8, 32'hA5A5A5A5);
        run_req("lb13",  0, 3'b000, 32'h13, 32'h0,        0, 32'hFFFFFFA5, 2'd0, 3, 2, 1, 32'h10, 4'hF, 32'h0);
        run_req("lbu13", 0, 3'b100, 32'h13, 32'h0,        0, 32'h000000A5, 2'd0, 3, 2, 1, 32'h10, 4'hF, 32'h0);
        run_req("sh12",  1, 3'b001, 32'h12, 32'h00008001, 0, 32'h0,        2'd0, 3, 2, 1, 32'h10, 4'hC, 32'h80018001);
        run_req("lh12",  0, 3'b001, 32'h12, 32'h0,        0, 32'hFFFF8001, 2'd0, 3, 2, 1, 32'h10, 4'hF, 32'h0);
        run_req("lhu12", 0, 3'b101, 32'h12, 32'h0,        0, 32'h00008001, 2'd0, 3, 2, 1, 32'h10, 4'hF, 32'h0);
        run_req("lw10b", 0, 3'b010, 32'h10, 32'h0,        0, 32'h8001BEEF, 2'd0, 3, 2, 1, 32'h10, 4'hF, 32'h0);
        run_req("lb11",  0, 3'b000, 32'h11, 32'h0,        0, 32'hFFFFFFBE, 2'd0, 3, 2, 1, 32'h10, 4'hF, 32'h0);
        run_req("lbu11", 0, 3'b100, 32'h11, 32'h0,        0, 32'h000000BE, 2'd0, 3, 2, 1, 32'h10, 4'hF, 32'h0);
        run_req("lh10",  0, 3'b001, 32'h10, 32'h0,        0, 32'hFFFFBEEF, 2'd0, 3, 2, 1, 32'h10, 4'hF, 32'h0);
        run_req("lhu10", 0, 3'b101, 32'h10, 32'h0,        0, 32'h0000BEEF, 2'd0, 3, 2, 1, 32'h10, 4'hF, 32'h0);
        // faults: no bus cycle, one-cycle response
        run_req("lw11",  0, 3'b010, 32'h11, 32'h0,        0, 32'h0,        2'd1, 1, 0, 0, 32'h0,  4'h0, 32'h0);
        run_req("lh13",  0, 3'b001, 32'h13, 32'h0,        0, 32'h0,        2'd1, 1, 0, 0, 32'h0,  4'h0, 32'h0);
        run_req("ld011", 0, 3'b011, 32'h10, 32'h0,        0, 32'h0,        2'd2, 1, 0, 0, 32'h0,  4'h0, 32'h0);
        run_req("st100", 1, 3'b100, 32'h10, 32'h12345678, 0, 32'h0,        2'd2, 1, 0, 0, 32'h0,  4'h0, 32'h0);
        run_req("sw12",  1, 3'b010, 32'h12, 32'h12345678, 0, 32'h0,        2'd1, 1, 0, 0, 32'h0,  4'h0, 32'h0);
        run_req("lw10c", 0, 3'b010, 32'h10, 32'h0,        0, 32'h8001BEEF, 2'd0, 3, 2, 1, 32'h10, 4'hF, 32'h0);

        // slave stalls 3 cycles then never acks: timeout after TO cycles of cyc
        slv_stall_left = 3;
        slv_noack = 1'b1;
        run_req("tmo20", 0, 3'b010, 32'h20, 32'h0,        1, 32'h0,        2'd3, 17, 16, 4, 32'h20, 4'hF, 32'h0);
        slv_noack = 1'b0;
        run_req("lw10d", 0, 3'b010, 32'h10, 32'h0,        0, 32'h8001BEEF, 2'd0, 3, 2, 1, 32'h10, 4'hF, 32'h0);
        run_req("sw10b", 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0,        2'd0, 3, 2, 1, 32'h10, 4'hF, 32'hDEADBEEF);

        // asynchronous reset while waiting for an ack
        slv_noack = 1'b1;
        exp_addr = 32'h10;
        exp_sel  = 4'hF;
        exp_we   = 1'b0;
        @(posedge clk);
        #1;
        req_is_store = 1'b0;
        req_funct3   = 3'b010;
        req_addr     = 32'h10;
        req_valid    = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("wait_ack cyc", 32'(wb_cyc), 32'(1));
        chk("wait_ack stb", 32'(wb_stb), 32'(0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst cyc", 32'(wb_cyc), 32'(0));
        chk("async rst stb", 32'(wb_stb), 32'(0));
        chk("async rst rsp_valid", 32'(rsp_valid), 32'(0));
        chk("async rst mem_stall", 32'(mem_stall), 32'(1));
        req_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        slv_noack = 1'b0;
        run_req("lw10e", 0, 3'b010, 32'h10, 32'h0,        0, 32'hDEADBEEF, 2'd0, 3, 2, 1, 32'h10, 4'hF, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("exp_q drained", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
